// File: rtl/product_accumulator.sv
// Accumulates BATCH unsigned 8-bit products into one ACC_W-bit sum with a sticky overflow flag.
// Latency: result valid 1 cycle after the final accept; input stalls (in_ready=0) while a result is held.
module product_accumulator #(
    parameter int BATCH = 8,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_product,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [3:0]       count
);

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [3:0]         r_count;
    logic [ACC_W-1:0]   r_sum;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_last;
    logic [ACC_W:0]     w_add;

    // One extra bit on the adder so the carry-out feeds the sticky overflow flag.
    assign w_add    = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, in_product};
    assign w_accept = in_valid && (r_state == ACC);
    assign w_last   = (r_count == 4'(BATCH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state   <= ACC;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_count   <= '0;
            r_sum     <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_sum     <= w_add[ACC_W-1:0];
                            r_out_ovf <= r_ovf | w_add[ACC_W];
                            r_acc     <= '0;
                            r_ovf     <= 1'b0;
                            r_count   <= '0;
                            r_state   <= HOLD;
                        end else begin
                            r_acc     <= w_add[ACC_W-1:0];
                            r_ovf     <= r_ovf | w_add[ACC_W];
                            r_count   <= r_count + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= ACC;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

    // Handshake flags depend only on state, so neither valid nor ready has a combinational path.
    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == HOLD);
    assign out_sum   = r_sum;
    assign out_ovf   = r_out_ovf;
    assign count     = r_count;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: default-parameter instance plus an ACC_W=8/BATCH=2 instance for wrap/overflow.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [7:0]  a_in_product;
    logic [11:0] a_out_sum;
    logic [3:0]  a_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [7:0]  b_in_product;
    logic [7:0]  b_out_sum;
    logic [3:0]  b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_accumulator dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (a_in_valid),
        .in_product (a_in_product),
        .in_ready   (a_in_ready),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_sum    (a_out_sum),
        .out_ovf    (a_out_ovf),
        .count      (a_count)
    );

    product_accumulator #(.BATCH(2), .ACC_W(8)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (1'b0),
        .in_valid   (b_in_valid),
        .in_product (b_in_product),
        .in_ready   (b_in_ready),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_sum    (b_out_sum),
        .out_ovf    (b_out_ovf),
        .count      (b_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        a_in_valid = 1'b0; a_in_product = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_product = '0; b_out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready",  32'(a_in_ready), 1);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_sum",   32'(a_out_sum), 0);
        chk("rst_out_ovf",   32'(a_out_ovf), 0);
        chk("rst_count",     32'(a_count), 0);

        // 8 back-to-back beats of 225
        a_in_valid = 1'b1; a_in_product = 8'd225;
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_count7", 32'(a_count), 7);
        chk("b2b_noval7", 32'(a_out_valid), 0);
        tick();
        a_in_valid = 1'b0;
        chk("b2b_valid",    32'(a_out_valid), 1);
        chk("b2b_sum",      32'(a_out_sum), 1800);
        chk("b2b_ovf",      32'(a_out_ovf), 0);
        chk("b2b_count0",   32'(a_count), 0);
        chk("b2b_in_ready", 32'(a_in_ready), 0);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("b2b_consumed", 32'(a_out_valid), 0);
        chk("b2b_ready_bk", 32'(a_in_ready), 1);

        // Beats 1..8 with bubbles, then a stalled result
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1; a_in_product = 8'(i);
            tick();
            a_in_valid = 1'b0;
            tick();
        end
        chk("bub_valid", 32'(a_out_valid), 1);
        a_in_valid = 1'b1; a_in_product = 8'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bub_hold_sum",   32'(a_out_sum), 36);
            chk("bub_hold_ready", 32'(a_in_ready), 0);
            chk("bub_hold_valid", 32'(a_out_valid), 1);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("bub_ready_bk", 32'(a_in_ready), 1);
        chk("bub_released", 32'(a_out_valid), 0);
        chk("bub_no_accept", 32'(a_count), 0);
        a_in_valid = 1'b0;

        // Narrow instance: modulo wrap and overflow flag, then clean batch
        b_in_valid = 1'b1; b_in_product = 8'd200;
        tick();
        chk("b_count1", 32'(b_count), 1);
        b_in_product = 8'd100;
        tick();
        b_in_valid = 1'b0;
        chk("b_valid", 32'(b_out_valid), 1);
        chk("b_sum44", 32'(b_out_sum), 44);
        chk("b_ovf1",  32'(b_out_ovf), 1);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_product = 8'd1;
        tick();
        b_in_product = 8'd2;
        tick();
        b_in_valid = 1'b0;
        chk("b_sum3", 32'(b_out_sum), 3);
        chk("b_ovf0", 32'(b_out_ovf), 0);

        // Clear mid-batch drops the simultaneous beat
        a_in_valid = 1'b1; a_in_product = 8'd10;
        tick(); tick(); tick();
        chk("clr_count3", 32'(a_count), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_count0", 32'(a_count), 0);
        chk("clr_ready",  32'(a_in_ready), 1);
        a_in_product = 8'd1;
        for (int i = 0; i < 8; i++) tick();
        a_in_valid = 1'b0;
        chk("clr_valid", 32'(a_out_valid), 1);
        chk("clr_sum8",  32'(a_out_sum), 8);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;

        // Clear beats out_ready while holding 1800
        a_in_valid = 1'b1; a_in_product = 8'd225;
        for (int i = 0; i < 8; i++) tick();
        a_in_valid = 1'b0;
        chk("clrh_sum", 32'(a_out_sum), 1800);
        clear = 1'b1; a_out_ready = 1'b1;
        tick();
        clear = 1'b0; a_out_ready = 1'b0;
        chk("clrh_valid", 32'(a_out_valid), 0);
        chk("clrh_sum0",  32'(a_out_sum), 0);
        chk("clrh_ready", 32'(a_in_ready), 1);

        // Reset mid-batch, with clear also asserted
        a_in_valid = 1'b1; a_in_product = 8'd7;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_mid_count5", 32'(a_count), 5);
        a_in_valid = 1'b0; rst_n = 1'b0; clear = 1'b1;
        tick();
        rst_n = 1'b1; clear = 1'b0;
        chk("rst_mid_count0", 32'(a_count), 0);
        chk("rst_mid_valid",  32'(a_out_valid), 0);
        a_in_valid = 1'b1; a_in_product = 8'd2;
        for (int i = 0; i < 8; i++) tick();
        a_in_valid = 1'b0;
        chk("rst_mid_valid2", 32'(a_out_valid), 1);
        chk("rst_mid_sum16",  32'(a_out_sum), 16);
        chk("rst_mid_ovf",    32'(a_out_ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter BATCH, default 8: number of products summed per result; legal range 2..16.
REQ-003 Parameter ACC_W, default 12: accumulator and result width; legal range 8..16.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 clear  input  1  synchronous abort; discards partial batch and any held result.
REQ-007 in_valid  input  1  in_product is valid this cycle.
REQ-008 in_product  input  8  unsigned 8-bit product from the upstream 4x4 array multiplier.
REQ-009 in_ready  output  1  block accepts in_product this cycle.
REQ-010 out_valid  output  1  out_sum/out_ovf hold a completed batch result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 out_sum  output  ACC_W  sum of BATCH accepted products, modulo 2^ACC_W.
REQ-013 out_ovf  output  1  result exceeded 2^ACC_W-1 during its batch.
REQ-014 count  output  4  products accepted in the current partial batch.

Function
REQ-015 FSM SHALL have two states: ACC (collecting) and HOLD (result presented).
REQ-016 In ACC, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-017 Accept = in_valid & in_ready; on accept, acc <= acc + zero-extended in_product and count <= count+1.
REQ-018 Cycles with in_valid=0 in ACC SHALL leave acc and count unchanged (bubbles allowed).
REQ-019 Accept with count==BATCH-1 SHALL load out_sum <= acc+in_product, clear acc and count to 0, and enter HOLD next cycle (out_valid high 1 cycle after final accept).
REQ-020 Addition carry-out beyond ACC_W SHALL set a sticky batch overflow bit; it is copied to out_ovf with the result and cleared with acc.
REQ-021 out_sum and out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 In HOLD, out_ready=1 SHALL return FSM to ACC next cycle; in_ready rises that cycle, so minimum spacing between results is BATCH+1 cycles.
REQ-023 in_product offered in HOLD SHALL be ignored (not accepted, not lost-counted); upstream must hold it until in_ready=1.
REQ-024 clear=1 SHALL, next cycle, force ACC, acc=0, count=0, overflow bit=0, out_valid=0, out_sum=0, out_ovf=0, regardless of in_valid/out_ready that cycle.
REQ-025 clear SHALL take priority over a simultaneous accept or out_ready; the product offered that cycle is dropped.
REQ-026 out_sum, out_ovf and count SHALL be registered outputs; in_ready and out_valid SHALL be decoded directly from the FSM state only (no combinational path from in_valid or out_ready).

Reset
REQ-027 rst_n=0 at a clock edge SHALL set state ACC, acc=0, count=0, overflow bit=0, out_sum=0, out_ovf=0; hence in_ready=1, out_valid=0.
REQ-028 Reset asserted mid-batch or in HOLD SHALL discard all partial and held data; first accept after release starts a fresh batch at count=0.
REQ-029 rst_n SHALL dominate clear.

Verification
REQ-030 Defaults, 8 back-to-back beats of 225 (15x15) -> out_valid 1 cycle after 8th accept, out_sum=1800 (0x708), out_ovf=0, count returns 0.
REQ-031 Defaults, beats 1..8 with in_valid toggled every other cycle, out_ready held 0 for 5 cycles -> out_sum=36 stable throughout hold, in_ready=0 in HOLD, then in_ready=1 cycle after out_ready.
REQ-032 ACC_W=8, BATCH=2, beats 200,100 -> out_sum=44 (300 mod 256), out_ovf=1; next batch 1,2 -> out_sum=3, out_ovf=0.
REQ-033 Defaults, 3 beats of 10, then clear with in_valid=1 -> count=0, no accept; next 8 beats of 1 -> out_sum=8.
REQ-034 Defaults, in HOLD with out_sum=1800, assert clear and out_ready same cycle -> out_valid=0, out_sum=0 next cycle, state ACC.
REQ-035 Defaults, rst_n=0 for 1 cycle after 5 beats of 7 -> count=0, out_valid=0; next 8 beats of 2 -> out_sum=16.
